xor_decryptor: RTL and testbench



---
 rtl/decrypt_pkg.sv | 22 ++
 rtl/keystream_gen.sv | 42 ++++
 rtl/xor_decryptor.sv | 117 +++++++++++
 tb/tb_xor_decryptor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decrypt_pkg.sv
// Shared constants, FSM state type and rotate helper for the XOR decryptor.
package decrypt_pkg;

   localparam int DATA_W_DFLT = 16;

   typedef enum logic [0:0] {NO_KEY = 1'b0, RUN = 1'b1} state_t;

   // Width-generic left rotate on the low `width` bits; bits above width are zero.
   function automatic logic [63:0] rotl(input logic [63:0] value, input int amount, input int width);
      logic [63:0] r;
      int          src;
      r = '0;
      for (int i = 0; i < 64; i++) begin
         if (i < width) begin
            src  = (i + width - (amount % width)) % width;
            r[i] = value[6'(src)];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/keystream_gen.sv
// Rolling keystream: holds the base key and the current rotated key.
module keystream_gen
   import decrypt_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int ROT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              advance,
   input  logic              restart,
   input  logic [DATA_W-1:0] key,
   output logic [DATA_W-1:0] cur_key
);

   logic [DATA_W-1:0] base_reg;
   logic [DATA_W-1:0] cur_reg;
   logic [63:0]       rot_full;
   logic [DATA_W-1:0] rot_next;
   logic              unused_rot;

   assign rot_full   = rotl(64'(cur_reg), ROT, DATA_W);
   assign rot_next   = rot_full[DATA_W-1:0];
   assign unused_rot = ^rot_full;
   assign cur_key    = cur_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         base_reg <= '0;
         cur_reg  <= '0;
      end else if (load) begin
         base_reg <= key;
         cur_reg  <= key;
      end else if (restart) begin
         cur_reg <= base_reg;
      end else if (advance) begin
         cur_reg <= rot_next;
      end
   end

endmodule

// File: rtl/xor_decryptor.sv
// XOR stream decryptor with valid/ready on both sides and one registered output stage.
// Optional per-message plaintext checksum is enabled by defining DECRYPT_CHECKSUM_EN.
module xor_decryptor
   import decrypt_pkg::*;
#(
   parameter int DATA_W = DATA_W_DFLT,
   parameter int ROT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] key_in,
   input  logic              key_load,
   output logic              key_loaded,
   input  logic [DATA_W-1:0] ct_data,
   input  logic              ct_last,
   input  logic              ct_valid,
   output logic              ct_ready,
   output logic [DATA_W-1:0] pt_data,
   output logic              pt_last,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [15:0]       word_cnt
`ifdef DECRYPT_CHECKSUM_EN
   ,
   input  logic [DATA_W-1:0] chk_expected,
   output logic              chk_ok,
   output logic              chk_valid
`endif
);

   state_t            state_reg;
   logic [DATA_W-1:0] pt_data_reg;
   logic              pt_last_reg;
   logic              pt_valid_reg;
   logic [15:0]       cnt_reg;
   logic [DATA_W-1:0] cur_key;
   logic              accept;

   assign key_loaded = (state_reg == RUN);
   // key_load always wins over a ciphertext handshake in the same cycle.
   assign ct_ready   = key_loaded & ~key_load & (~pt_valid_reg | pt_ready);
   assign accept     = ct_valid & ct_ready;

   assign pt_data  = pt_data_reg;
   assign pt_last  = pt_last_reg;
   assign pt_valid = pt_valid_reg;
   assign word_cnt = cnt_reg;

   keystream_gen #(
      .DATA_W (DATA_W),
      .ROT    (ROT)
   ) u_keystream (
      .clk     (clk),
      .rst     (rst),
      .load    (key_load),
      .advance (accept & ~ct_last),
      .restart (accept & ct_last),
      .key     (key_in),
      .cur_key (cur_key)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= NO_KEY;
         pt_data_reg  <= '0;
         pt_last_reg  <= 1'b0;
         pt_valid_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         if (key_load) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
         end else if (accept) begin
            cnt_reg <= ct_last ? 16'd0 : cnt_reg + 16'd1;
         end
         if (accept) begin
            pt_data_reg  <= ct_data ^ cur_key;
            pt_last_reg  <= ct_last;
            pt_valid_reg <= 1'b1;
         end else if (pt_ready) begin
            pt_valid_reg <= 1'b0;
         end
      end
   end

`ifdef DECRYPT_CHECKSUM_EN
   logic [DATA_W-1:0] acc_reg;
   logic              chk_ok_reg;
   logic              chk_valid_reg;
   logic              pt_fire;

   assign pt_fire   = pt_valid_reg & pt_ready;
   assign chk_ok    = chk_ok_reg;
   assign chk_valid = chk_valid_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         chk_ok_reg    <= 1'b0;
         chk_valid_reg <= 1'b0;
      end else begin
         chk_valid_reg <= 1'b0;
         if (pt_fire && pt_last_reg) begin
            chk_valid_reg <= 1'b1;
            chk_ok_reg    <= ((acc_reg ^ pt_data_reg) == chk_expected);
            acc_reg       <= '0;
         end else if (pt_fire) begin
            acc_reg <= acc_reg ^ pt_data_reg;
         end
         if (key_load) begin
            acc_reg <= '0;
         end
      end
   end
`endif

endmodule

// File: tb/tb_xor_decryptor.sv
// Self-checking bench for xor_decryptor: vector table, hand sequences and a randomized model run.
module tb_xor_decryptor;

   localparam int W   = 16;
   localparam int ROT = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  key_in;
   logic          key_load;
   logic          key_loaded;
   logic [W-1:0]  ct_data;
   logic          ct_last;
   logic          ct_valid;
   logic          ct_ready;
   logic [W-1:0]  pt_data;
   logic          pt_last;
   logic          pt_valid;
   logic          pt_ready;
   logic [15:0]   word_cnt;
`ifdef DECRYPT_CHECKSUM_EN
   logic [W-1:0]  chk_expected;
   logic          chk_ok;
   logic          chk_valid;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   xor_decryptor #(.DATA_W(W), .ROT(ROT)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .key_load   (key_load),
      .key_loaded (key_loaded),
      .ct_data    (ct_data),
      .ct_last    (ct_last),
      .ct_valid   (ct_valid),
      .ct_ready   (ct_ready),
      .pt_data    (pt_data),
      .pt_last    (pt_last),
      .pt_valid   (pt_valid),
      .pt_ready   (pt_ready),
      .word_cnt   (word_cnt)
`ifdef DECRYPT_CHECKSUM_EN
      ,
      .chk_expected (chk_expected),
      .chk_ok       (chk_ok),
      .chk_valid    (chk_valid)
`endif
   );

   typedef struct {
      logic [W-1:0] ct;
      logic         last;
      logic [W-1:0] exp_pt;
      logic         exp_last;
      logic [15:0]  exp_cnt;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      key_load = 1'b0;
      ct_valid = 1'b0;
      ct_last  = 1'b0;
      ct_data  = '0;
   endtask

   task automatic load_key(input logic [W-1:0] k);
      key_in   = k;
      key_load = 1'b1;
      tick();
      key_load = 1'b0;
   endtask

   // Keystream after n accepted words of a message: base key rotated left by n*ROT.
   function automatic logic [W-1:0] ref_key(input logic [W-1:0] base, input int n);
      logic [31:0] t;
      int          s;
      s = (n * ROT) % W;
      t = {base, base} << s;
      return t[31:16];
   endfunction

   // Reference model state for the randomized run.
   logic         m_loaded;
   logic [W-1:0] m_base;
   int           m_idx;
   logic         m_pv;
   logic [W-1:0] m_pd;
   logic         m_pl;
   logic [15:0]  m_cnt;

   initial begin
      rst      = 1'b1;
      key_in   = '0;
      pt_ready = 1'b1;
      idle_inputs();
`ifdef DECRYPT_CHECKSUM_EN
      chk_expected = '0;
`endif
      vecs[0] = '{16'hA13D, 1'b0, 16'hB309, 1'b0, 16'd1};
      vecs[1] = '{16'h0000, 1'b1, 16'h2468, 1'b1, 16'd0};
      vecs[2] = '{16'hA13D, 1'b0, 16'hB309, 1'b0, 16'd1};
      vecs[3] = '{16'h0000, 1'b0, 16'h2468, 1'b0, 16'd2};
      vecs[4] = '{16'hFFFF, 1'b0, 16'hB72F, 1'b0, 16'd3};
      vecs[5] = '{16'h0000, 1'b1, 16'h91A0, 1'b1, 16'd0};

      tick();
      tick();
      rst = 1'b0;
      #1;
      check("reset key_loaded", 32'(key_loaded), 32'd0);
      check("reset pt_valid",   32'(pt_valid),   32'd0);
      check("reset pt_data",    32'(pt_data),    32'd0);
      check("reset pt_last",    32'(pt_last),    32'd0);
      check("reset word_cnt",   32'(word_cnt),   32'd0);
      $display("reset checked");

      // Without a key nothing is accepted.
      ct_valid = 1'b1;
      ct_data  = 16'h5555;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("nokey ct_ready", 32'(ct_ready), 32'd0);
         tick();
         check("nokey pt_valid", 32'(pt_valid), 32'd0);
      end
      ct_valid = 1'b0;
      key_in   = 16'h1234;
      key_load = 1'b1;
      #1;
      check("keyload ct_ready", 32'(ct_ready), 32'd0);
      tick();
      key_load = 1'b0;
      #1;
      check("after key ct_ready",   32'(ct_ready),   32'd1);
      check("after key key_loaded", 32'(key_loaded), 32'd1);
      $display("no-key sequence done");

      // Vector table, full throughput.
      for (int i = 0; i < 6; i++) begin
         ct_data  = vecs[i].ct;
         ct_last  = vecs[i].last;
         ct_valid = 1'b1;
         #1;
         check("vec ct_ready", 32'(ct_ready), 32'd1);
         tick();
         check("vec pt_valid", 32'(pt_valid), 32'd1);
         check("vec pt_data",  32'(pt_data),  32'(vecs[i].exp_pt));
         check("vec pt_last",  32'(pt_last),  32'(vecs[i].exp_last));
         check("vec word_cnt", 32'(word_cnt), 32'(vecs[i].exp_cnt));
         $display("vec %0d ct=%h last=%0b -> pt=%h", i, vecs[i].ct, vecs[i].last, pt_data);
      end
      idle_inputs();
      tick();
      check("drain pt_valid", 32'(pt_valid), 32'd0);

      // Backpressure: output held, input stalled, then back-to-back.
      load_key(16'h1234);
      pt_ready = 1'b0;
      ct_data  = 16'hA13D;
      ct_valid = 1'b1;
      tick();
      check("bp pt_valid", 32'(pt_valid), 32'd1);
      check("bp pt_data",  32'(pt_data),  32'hB309);
      ct_data = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp ct_ready", 32'(ct_ready), 32'd0);
         tick();
         check("bp hold data",  32'(pt_data),  32'hB309);
         check("bp hold valid", 32'(pt_valid), 32'd1);
      end
      pt_ready = 1'b1;
      #1;
      check("bp release ct_ready", 32'(ct_ready), 32'd1);
      tick();
      check("b2b pt_valid", 32'(pt_valid), 32'd1);
      check("b2b pt_data",  32'(pt_data),  32'h2468);
      check("b2b word_cnt", 32'(word_cnt), 32'd2);
      idle_inputs();
      tick();
      check("bp drain", 32'(pt_valid), 32'd0);
      $display("backpressure sequence done");

      // Collision: key_load beats a simultaneous ciphertext word.
      key_in   = 16'hFFFF;
      key_load = 1'b1;
      ct_data  = 16'h1234;
      ct_valid = 1'b1;
      #1;
      check("coll ct_ready", 32'(ct_ready), 32'd0);
      tick();
      key_load = 1'b0;
      check("coll pt_valid", 32'(pt_valid), 32'd0);
      check("coll word_cnt", 32'(word_cnt), 32'd0);
      ct_data = 16'hFFFF;
      tick();
      check("coll pt_data",  32'(pt_data),  32'h0000);
      check("coll pt_valid2", 32'(pt_valid), 32'd1);
      idle_inputs();
      tick();
      $display("collision sequence done");

`ifdef DECRYPT_CHECKSUM_EN
      for (int pass = 0; pass < 2; pass++) begin
         chk_expected = (pass == 0) ? (16'hB309 ^ 16'h2468) : 16'h0000;
         load_key(16'h1234);
         ct_valid = 1'b1;
         ct_data  = 16'hA13D;
         tick();
         ct_data = 16'h0000;
         ct_last = 1'b1;
         tick();
         idle_inputs();
         tick();
         check("chk_valid pulse", 32'(chk_valid), 32'd1);
         check("chk_ok", 32'(chk_ok), (pass == 0) ? 32'd1 : 32'd0);
         tick();
         check("chk_valid end", 32'(chk_valid), 32'd0);
         $display("checksum pass %0d expected=%h ok=%0b", pass, chk_expected, chk_ok);
      end
`endif

      // Randomized run against the reference model.
      m_loaded = 1'b0;
      m_base   = '0;
      m_idx    = 0;
      m_pv     = 1'b0;
      m_pd     = '0;
      m_pl     = 1'b0;
      m_cnt    = '0;
      rst      = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic exp_ready;
         logic acc;
         key_load = (cyc == 3) || ($urandom_range(0, 49) == 0);
         key_in   = W'($urandom);
         ct_valid = ($urandom_range(0, 3) != 0);
         ct_data  = W'($urandom);
         ct_last  = ($urandom_range(0, 3) == 0);
         pt_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = m_loaded && !key_load && (!m_pv || pt_ready);
         check("rnd ct_ready", 32'(ct_ready), 32'(exp_ready));
         acc = ct_valid && exp_ready;
         if (m_pv && pt_ready) m_pv = 1'b0;
         if (acc) begin
            m_pd  = ct_data ^ ref_key(m_base, m_idx);
            m_pl  = ct_last;
            m_pv  = 1'b1;
            m_idx = ct_last ? 0 : m_idx + 1;
            m_cnt = ct_last ? 16'd0 : m_cnt + 16'd1;
            $display("rnd %0d accept ct=%h last=%0b -> pt=%h", cyc, ct_data, ct_last, m_pd);
         end
         if (key_load) begin
            m_base   = key_in;
            m_idx    = 0;
            m_cnt    = '0;
            m_loaded = 1'b1;
         end
         tick();
         check("rnd pt_valid", 32'(pt_valid), 32'(m_pv));
         check("rnd word_cnt", 32'(word_cnt), 32'(m_cnt));
         if (m_pv) begin
            check("rnd pt_data", 32'(pt_data), 32'(m_pd));
            check("rnd pt_last", 32'(pt_last), 32'(m_pl));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
